triangle_feeder: RTL and testbench

TRIANGLE_FEEDER -- requirements
Module: triangle_feeder

---
 rtl/ddd_pkg.sv | 33 +++
 rtl/triangle_feeder_pipeline.sv | 26 ++
 rtl/triangle_feeder.sv | 166 ++++++++++++++++
 tb/tb_triangle_feeder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ddd_pkg.sv
// ddd_pkg: shared vertex, color and triangle-word layout for the 3D pipeline
package ddd_pkg;

    localparam int COORD_W   = 16;
    localparam int VERTEX_W  = 3 * COORD_W;
    localparam int COLOR_W   = 16;
    localparam int WORD_W    = COLOR_W + 3 * VERTEX_W;
    localparam int COLOR_LSB = 3 * VERTEX_W;
    localparam int V1_LSB    = 2 * VERTEX_W;
    localparam int V2_LSB    = VERTEX_W;
    localparam int V3_LSB    = 0;

    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
        logic signed [COORD_W-1:0] z;
    } vec3_t;

    // Component-wise difference; 16-bit wrap-around is intended.
    function automatic vec3_t vec_sub(input vec3_t a, input vec3_t b);
        vec3_t d;
        d.x = a.x - b.x;
        d.y = a.y - b.y;
        d.z = a.z - b.z;
        return d;
    endfunction

    // Vertex idx (0 = v1, 1 = v2, 2 = v3) of a triangle-memory word.
    function automatic vec3_t word_vertex(input logic [WORD_W-1:0] w, input int idx);
        return w[V1_LSB - idx * VERTEX_W +: VERTEX_W];
    endfunction

endpackage

// File: rtl/triangle_feeder_pipeline.sv
// triangle_feeder_pipeline: fixed-depth register delay line with sync clear
module triangle_feeder_pipeline #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_sr [DEPTH];

    // Shift the input through DEPTH stages; reset flushes anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) r_sr[k] <= '0;
        end else begin
            r_sr[0] <= i_data;
            for (int k = 1; k < DEPTH; k++) r_sr[k] <= r_sr[k-1];
        end
    end

    assign o_data = r_sr[DEPTH-1];

endmodule

// File: rtl/triangle_feeder.sv
// triangle_feeder: streams one frame of triangles as camera-relative vertices
module triangle_feeder
    import ddd_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int BRAM_LATENCY = 2,
    parameter int NEAR_Z       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   tri_count,
    input  logic [VERTEX_W-1:0]   camera_pos,
    output logic [ADDR_WIDTH-1:0] tri_addr,
    input  logic [WORD_W-1:0]     tri_data,
    output logic [VERTEX_W-1:0]   vertex,
    output logic [COLOR_W-1:0]    color,
    output logic                  new_triangle_out,
    output logic                  done_out,
    output logic                  busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PRIME  = 2'd1;
    localparam logic [1:0] S_EMIT   = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    localparam logic signed [COORD_W-1:0] NEAR_Z_C = COORD_W'(NEAR_Z);
    localparam logic [ADDR_WIDTH:0]       CNT_ONE  = (ADDR_WIDTH + 1)'(1);

    logic [1:0]            r_state;
    vec3_t                 r_cam;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_rd;
    logic [ADDR_WIDTH:0]   r_iss_left;
    logic [1:0]            r_iss_ph;
    logic [ADDR_WIDTH:0]   r_emit_left;
    vec3_t [2:0]           r_stage;
    logic [COLOR_W-1:0]    r_stage_color;
    logic                  r_vis;
    logic                  r_act;
    logic [1:0]            r_vsel;
    logic [VERTEX_W-1:0]   r_vertex;
    logic [COLOR_W-1:0]    r_color;
    logic                  r_new;
    logic                  r_done;

    logic        w_accept;
    logic        w_active;
    logic        w_rd_dly;
    logic        w_load;
    logic        w_last_vtx;
    logic        w_show;
    logic        w_vis;
    vec3_t [2:0] w_rel;

    // A start pulse is taken only when fully idle, including the done cycle.
    assign w_accept   = start && r_state == S_IDLE && !r_done;
    assign w_active   = r_state == S_PRIME || r_state == S_EMIT;
    assign w_load     = w_rd_dly && w_active;
    assign w_last_vtx = r_act && r_vsel == 2'd2;
    assign w_show     = r_act && r_vis;
    assign w_vis      = w_rel[0].z >= NEAR_Z_C && w_rel[1].z >= NEAR_Z_C && w_rel[2].z >= NEAR_Z_C;

    // Camera-relative vertices of the word currently on the memory bus.
    always_comb begin
        for (int k = 0; k < 3; k++) w_rel[k] = vec_sub(word_vertex(tri_data, k), r_cam);
    end

    triangle_feeder_pipeline #(
        .WIDTH (1),
        .DEPTH (BRAM_LATENCY)
    ) u_rd_valid (
        .clk    (clk),
        .rst    (rst),
        .i_data (r_rd),
        .o_data (w_rd_dly)
    );

    // Frame sequencing: zero-length frames skip straight to the done cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (w_accept) r_state <= (tri_count == '0) ? S_FINISH : S_PRIME;
                S_PRIME:  if (w_load) r_state <= S_EMIT;
                S_EMIT:   if (w_last_vtx && r_emit_left == CNT_ONE) r_state <= S_FINISH;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // Read issue: one address every 3 cycles so fetches match the slot rate.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_rd       <= 1'b0;
            r_iss_left <= '0;
            r_iss_ph   <= '0;
            r_cam      <= '0;
        end else if (w_accept) begin
            r_addr     <= '0;
            r_rd       <= tri_count != '0;
            r_iss_left <= (tri_count == '0) ? '0 : tri_count - CNT_ONE;
            r_iss_ph   <= '0;
            r_cam      <= camera_pos;
        end else if (w_active) begin
            r_rd       <= r_iss_ph == 2'd2 && r_iss_left != '0;
            r_addr     <= (r_iss_ph == 2'd2 && r_iss_left != '0) ? r_addr + 1'b1 : r_addr;
            r_iss_left <= (r_iss_ph == 2'd2 && r_iss_left != '0) ? r_iss_left - CNT_ONE : r_iss_left;
            r_iss_ph   <= (r_iss_ph == 2'd2) ? 2'd0 : r_iss_ph + 2'd1;
        end else begin
            r_rd       <= 1'b0;
            r_addr     <= '0;
        end
    end

    // Staging: capture each returning word so its three vertex cycles never stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_emit_left   <= '0;
            r_stage       <= '0;
            r_stage_color <= '0;
            r_vis         <= 1'b0;
            r_act         <= 1'b0;
            r_vsel        <= '0;
        end else begin
            if (w_accept) r_emit_left <= tri_count;
            else if (w_last_vtx && r_state == S_EMIT) r_emit_left <= r_emit_left - CNT_ONE;
            if (w_load) begin
                r_stage       <= w_rel;
                r_stage_color <= tri_data[COLOR_LSB +: COLOR_W];
                r_vis         <= w_vis;
                r_act         <= 1'b1;
                r_vsel        <= '0;
            end else if (r_act) begin
                r_vsel        <= r_vsel + 2'd1;
                r_act         <= r_vsel != 2'd2;
            end
        end
    end

    // Registered outputs: culled slots and idle cycles drive zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vertex <= '0;
            r_color  <= '0;
            r_new    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_vertex <= w_show ? r_stage[r_vsel] : '0;
            r_color  <= w_show ? r_stage_color : '0;
            r_new    <= w_show && r_vsel == 2'd0;
            r_done   <= r_state == S_FINISH;
        end
    end

    assign tri_addr         = r_addr;
    assign vertex           = r_vertex;
    assign color            = r_color;
    assign new_triangle_out = r_new;
    assign done_out         = r_done;
    assign busy             = r_state != S_IDLE || r_done;

endmodule

// File: tb/tb_triangle_feeder.sv
// tb_triangle_feeder: table-driven and randomized check of triangle_feeder
module tb_triangle_feeder;

    localparam int AW  = 8;
    localparam int LAT = 2;
    localparam int NZ  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   tri_count;
    logic [47:0]   camera_pos;
    logic [AW-1:0] tri_addr;
    logic [159:0]  tri_data;
    logic [47:0]   vertex;
    logic [15:0]   color;
    logic          new_triangle_out;
    logic          done_out;
    logic          busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [159:0] mem [0:255];
    logic [159:0] q   [0:LAT-1];

    typedef struct {
        int          n;
        logic [47:0] cam;
        int          kind;
        int          restart_at;
        int          rst_at;
        int          exp_done;
        int          exp_news;
        bit          check_v1;
        logic [47:0] exp_v1;
    } vec_t;

    vec_t tbl [7];

    triangle_feeder #(.ADDR_WIDTH(AW), .BRAM_LATENCY(LAT), .NEAR_Z(NZ)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .tri_count        (tri_count),
        .camera_pos       (camera_pos),
        .tri_addr         (tri_addr),
        .tri_data         (tri_data),
        .vertex           (vertex),
        .color            (color),
        .new_triangle_out (new_triangle_out),
        .done_out         (done_out),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    // Synchronous memory with LAT cycles of read latency.
    always @(posedge clk) begin
        q[0] <= mem[tri_addr];
        for (int k = 1; k < LAT; k++) q[k] <= q[k-1];
    end
    assign tri_data = q[LAT-1];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] rel(input logic [47:0] w, input logic [47:0] c);
        logic [15:0] dx, dy, dz;
        dx = w[47:32] - c[47:32];
        dy = w[31:16] - c[31:16];
        dz = w[15:0] - c[15:0];
        return {dx, dy, dz};
    endfunction

    function automatic logic [47:0] vtx_of(input logic [159:0] w, input int j);
        return w[96 - 48 * j +: 48];
    endfunction

    function automatic bit visible(input logic [159:0] w, input logic [47:0] cam);
        logic [47:0] r;
        for (int j = 0; j < 3; j++) begin
            r = rel(vtx_of(w, j), cam);
            if ($signed(r[15:0]) < NZ) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [47:0] rv(input logic [15:0] zbase, input int unsigned lo, input int unsigned hi);
        return {16'($urandom), 16'($urandom), zbase + 16'($urandom_range(hi, lo))};
    endfunction

    task automatic load_mem(input int kind, input logic [47:0] cam, input int n);
        logic [15:0] cz;
        cz = cam[15:0];
        case (kind)
            0: mem[0] = {16'hF800, 16'd10, 16'd20, 16'd100, 16'd30, 16'd40, 16'd200, 16'd50, 16'd60, 16'd300};
            1: for (int i = 0; i < n; i++) mem[i] = {16'($urandom), rv(cz, 16, 1000), rv(cz, 16, 1000), rv(cz, 16, 1000)};
            2: begin
                for (int i = 0; i < 3; i++) mem[i] = {16'h1234 + 16'(i), rv(cz, 200, 200), rv(cz, 200, 200), rv(cz, 200, 200)};
                mem[1][95:48] = {16'd5, 16'd6, 16'd110};
            end
            3: begin
                mem[0] = {16'h07E0, 16'h8000, 16'h0011, 16'h0100, 48'h0001_0002_012C, 48'h0003_0004_012C};
                mem[1] = {16'h001F, 48'h0000_0000_012C, 48'h0005_0006_012C, 48'h0007_0008_012C};
            end
            4: for (int i = 0; i < n; i++) mem[i] = {16'($urandom), rv(cz - 16'd4, 0, 60), rv(cz - 16'd4, 0, 60), rv(cz - 16'd4, 0, 60)};
            default: ;
        endcase
    endtask

    // Drives one frame and compares every cycle against the slot-rule model.
    task automatic run_frame(input vec_t v, input bit use_const);
        int          done_at, len, news, seen_done, s, i, j;
        bit          reset_hit, got_v;
        logic [47:0] ev, first_v;
        logic [15:0] ec;
        logic        en, ed, eb;
        logic [159:0] w;
        done_at   = (v.n == 0) ? 1 : LAT + 3 * v.n + 2;
        len       = done_at + 3;
        news      = 0;
        seen_done = -1;
        got_v     = 1'b0;
        first_v   = '0;
        for (int k = 0; k <= len; k++) begin
            @(negedge clk);
            start = (k == 0) || (k == v.restart_at);
            rst   = (k == v.rst_at);
            if (k == 0) begin
                tri_count  = (AW + 1)'(v.n);
                camera_pos = v.cam;
            end else begin
                tri_count  = (AW + 1)'($urandom);
                camera_pos = 48'({$urandom, $urandom});
            end
            @(posedge clk);
            #1;
            reset_hit = v.rst_at >= 0 && k >= v.rst_at;
            ev = '0;
            ec = '0;
            en = 1'b0;
            s  = k - (LAT + 2);
            if (s >= 0 && s < 3 * v.n && !reset_hit) begin
                i = s / 3;
                j = s % 3;
                w = mem[i];
                if (visible(w, v.cam)) begin
                    ev = rel(vtx_of(w, j), v.cam);
                    ec = w[159:144];
                    en = (j == 0);
                end
            end
            ed = !reset_hit && k == done_at;
            eb = !reset_hit && k <= done_at;
            check($sformatf("cycle%0d n=%0d out", k, v.n), {vertex, color, new_triangle_out, done_out, busy}, {ev, ec, en, ed, eb});
            if (!reset_hit && v.n == 0)
                check($sformatf("cycle%0d addr", k), 128'(tri_addr), 128'(0));
            else if (!reset_hit && k % 3 == 0 && k / 3 < v.n)
                check($sformatf("cycle%0d addr", k), 128'(tri_addr), 128'(k / 3));
            if (done_out && seen_done < 0) seen_done = k;
            if (new_triangle_out) begin
                news++;
                if (!got_v) first_v = vertex;
                got_v = 1'b1;
            end
        end
        start = 1'b0;
        rst   = 1'b0;
        if (use_const) begin
            check("done_offset", 128'(seen_done), 128'(v.exp_done));
            check("new_count", 128'(news), 128'(v.exp_news));
            if (v.check_v1) check("first_vertex", 128'(first_v), 128'(v.exp_v1));
        end
    endtask

    initial begin
        vec_t v;
        rst        = 1'b1;
        start      = 1'b0;
        tri_count  = '0;
        camera_pos = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        tbl[0] = '{1, 48'h0,                   0, -1, -1,  7, 1, 1'b1, 48'h000A_0014_0064};
        tbl[1] = '{4, 48'h0005_0006_0000,      1, -1, -1, 16, 4, 1'b0, 48'h0};
        tbl[2] = '{3, 48'h0000_0000_0064,      2, -1, -1, 13, 2, 1'b0, 48'h0};
        tbl[3] = '{0, 48'h0,                  -1, -1, -1,  1, 0, 1'b0, 48'h0};
        tbl[4] = '{5, 48'h0,                   1, -1,  8, -1, 2, 1'b0, 48'h0};
        tbl[5] = '{5, 48'h0,                  -1, -1, -1, 19, 5, 1'b0, 48'h0};
        tbl[6] = '{2, 48'h0001_0000_0000,      3,  5, -1, 10, 2, 1'b1, 48'h7FFF_0011_0100};
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {vertex, color, new_triangle_out, done_out, busy, tri_addr}, '0);
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 7; t++) begin
            if (tbl[t].kind >= 0) load_mem(tbl[t].kind, tbl[t].cam, tbl[t].n);
            run_frame(tbl[t], 1'b1);
        end
        for (int t = 0; t < 20; t++) begin
            v            = tbl[0];
            v.n          = $urandom_range(10, 0);
            v.cam        = 48'({$urandom, $urandom});
            v.rst_at     = -1;
            v.restart_at = (v.n > 0 && $urandom_range(1, 0) == 1) ? $urandom_range(LAT + 3 * v.n + 2, 1) : -1;
            load_mem(4, v.cam, v.n);
            run_frame(v, 1'b0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
